// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma scrambler: wirings, notches, reflector, rotor order and FSM states.
package enigma_pkg;

  localparam int unsigned ALPHA = 26;
  localparam int unsigned LW    = 5;
  localparam int unsigned MAX_ROTORS = 8;

  typedef enum logic [1:0] {
    RotorI   = 2'd0,
    RotorII  = 2'd1,
    RotorIII = 2'd2
  } rotor_id_e;

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StFwd,
    StRefl,
    StBwd,
    StDone
  } state_e;

  // Forward wirings, indexed [rotor_id][contact].
  localparam logic [LW-1:0] WIRE_FWD [3][ALPHA] = '{
    '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9},
    '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4},
    '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14}
  };

  // Inverse wirings: WIRE_INV[r][WIRE_FWD[r][i]] == i.
  localparam logic [LW-1:0] WIRE_INV [3][ALPHA] = '{
    '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9},
    '{5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18},
    '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12}
  };

  // Turnover positions: I=Q, II=E, III=V.
  localparam logic [LW-1:0] NOTCH [3] = '{5'd16, 5'd4, 5'd21};

  localparam logic [LW-1:0] REFLECTOR_B [ALPHA] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19
  };

  // Rotor k (0 = rightmost) uses ROTOR_SEL[k]; the classic order is III, II, I.
  localparam rotor_id_e ROTOR_SEL [MAX_ROTORS] = '{
    RotorIII, RotorII, RotorI, RotorIII, RotorII, RotorI, RotorIII, RotorII
  };

endpackage

// File: rtl/enigma_rotor_map.sv
// One rotor substitution: shift into the rotor frame, look up the wiring, shift back out.
module enigma_rotor_map
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA = enigma_pkg::ALPHA,
  parameter int unsigned W     = 5
) (
  input  logic [W-1:0] letter,
  input  logic [W-1:0] pos,
  input  rotor_id_e    rotor_id,
  input  logic         inverse,
  output logic [W-1:0] mapped
);

  localparam logic [W:0] AlphaX = (W+1)'(ALPHA);

  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] wired;

  // (WIRE[(c+p) mod ALPHA] - p) mod ALPHA, both reductions at W+1 bits.
  always_comb begin
    sum = {1'b0, letter} + {1'b0, pos};
    if (sum >= AlphaX) sum = sum - AlphaX;
    wired = inverse ? W'(WIRE_INV[rotor_id][sum[W-1:0]]) : W'(WIRE_FWD[rotor_id][sum[W-1:0]]);
    diff = {1'b0, wired} - {1'b0, pos};
    if (diff[W]) diff = diff + AlphaX;
    mapped = diff[W-1:0];
  end

endmodule

// File: rtl/enigma_rotor_stack.sv
// Clocked Enigma scrambler: steps the rotor stack, then walks one letter through
// rotors, reflector and back, one rotor per cycle, with valid/ready on both sides.
module enigma_rotor_stack
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA      = enigma_pkg::ALPHA,
  parameter int unsigned W          = 5,
  parameter int unsigned NUM_ROTORS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_load,
  input  logic [NUM_ROTORS*W-1:0] cfg_pos,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_char,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_char,
  output logic                    out_err,
  output logic [NUM_ROTORS*W-1:0] rotor_pos
);

  localparam int unsigned CntW   = $clog2(NUM_ROTORS);
  localparam logic [W:0]  AlphaX = (W+1)'(ALPHA);

  state_e                state_q;
  logic [W-1:0]          pos_q [NUM_ROTORS];
  logic [W-1:0]          char_q;
  logic [CntW-1:0]       cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [W-1:0]          out_char_q;
  logic                  out_err_q;

  logic [W-1:0]          pos_inc   [NUM_ROTORS];
  logic [W-1:0]          cfg_slice [NUM_ROTORS];
  logic [NUM_ROTORS-2:0] at_notch;
  logic [NUM_ROTORS-1:0] do_step;
  logic [W-1:0]          map_pos;
  rotor_id_e             map_id;
  logic [W-1:0]          map_out;

  // cfg_load takes priority over a letter, so hide in_ready while it is high.
  assign in_ready  = in_ready_q & ~cfg_load;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_err   = out_err_q;
  assign map_pos   = pos_q[cnt_q];
  assign map_id    = ROTOR_SEL[cnt_q];

  // Stepping decisions from pre-step positions, plus sanitised load values.
  always_comb begin
    do_step    = '0;
    do_step[0] = 1'b1;
    for (int k = 0; k < NUM_ROTORS - 1; k++) begin
      at_notch[k] = (pos_q[k] == W'(NOTCH[ROTOR_SEL[k]]));
    end
    for (int k = 1; k < NUM_ROTORS; k++) begin
      do_step[k] = at_notch[k-1];
      // Double-step: a middle rotor sitting on its own notch moves again.
      if (k < int'(NUM_ROTORS) - 1) do_step[k] = do_step[k] | at_notch[k];
    end
    for (int k = 0; k < NUM_ROTORS; k++) begin
      pos_inc[k]   = (pos_q[k] == W'(ALPHA - 1)) ? '0 : pos_q[k] + 1'b1;
      cfg_slice[k] = ({1'b0, cfg_pos[k*W +: W]} >= AlphaX) ? '0 : cfg_pos[k*W +: W];
      rotor_pos[k*W +: W] = pos_q[k];
    end
  end

  enigma_rotor_map #(
    .ALPHA(ALPHA),
    .W    (W)
  ) u_map (
    .letter  (char_q),
    .pos     (map_pos),
    .rotor_id(map_id),
    .inverse (state_q == StBwd),
    .mapped  (map_out)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int k = 0; k < NUM_ROTORS; k++) pos_q[k] <= '0;
      char_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (cfg_load) begin
            for (int k = 0; k < NUM_ROTORS; k++) pos_q[k] <= cfg_slice[k];
          end else if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if ({1'b0, in_char} >= AlphaX) begin
              out_char_q  <= in_char;
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              char_q  <= in_char;
              state_q <= StStep;
            end
          end
        end
        StStep: begin
          for (int k = 0; k < NUM_ROTORS; k++) begin
            if (do_step[k]) pos_q[k] <= pos_inc[k];
          end
          cnt_q   <= '0;
          state_q <= StFwd;
        end
        StFwd: begin
          char_q <= map_out;
          if (cnt_q == CntW'(NUM_ROTORS - 1)) begin
            state_q <= StRefl;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRefl: begin
          // cnt_q still points at the leftmost rotor, where the return path starts.
          char_q  <= W'(REFLECTOR_B[char_q]);
          state_q <= StBwd;
        end
        StBwd: begin
          char_q <= map_out;
          if (cnt_q == '0) begin
            out_char_q  <= map_out;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed bench for enigma_rotor_stack with hand-computed Enigma I/II/III + UKW-B vectors.
module tb_enigma_rotor_stack;

  localparam int unsigned W = 5;
  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           cfg_load = 1'b0;
  logic [N*W-1:0] cfg_pos = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_char = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_char;
  logic           out_err;
  logic [N*W-1:0] rotor_pos;

  int checks = 0;
  int failures = 0;

  enigma_rotor_stack #(
    .ALPHA     (26),
    .W         (W),
    .NUM_ROTORS(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_load (cfg_load),
    .cfg_pos  (cfg_pos),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_char (out_char),
    .out_err  (out_err),
    .rotor_pos(rotor_pos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [N*W-1:0] v);
    cfg_pos  = v;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Drives one letter (out_ready assumed 1) and returns result and extra edges to out_valid.
  task automatic send(input logic [W-1:0] ch, output logic [W-1:0] res, output logic err,
                      output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_in_ready_timeout: in_ready=%0d required 1", in_ready);
    end
    in_valid = 1'b1;
    in_char  = ch;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL send_out_valid_timeout: out_valid=%0d required 1", out_valid);
    end
    res = out_char;
    err = out_err;
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, out_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got in_ready/out_valid/out_err=%b required 000",
               {in_ready, out_valid, out_err});
    end
    checks++;
    if (out_char !== '0 || rotor_pos !== '0) begin
      failures++;
      $display("FAIL reset_data: got out_char=%0d rotor_pos=%h required 0 0", out_char, rotor_pos);
    end
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge: got %0d required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge: got %0d required 1", in_ready);
    end
  endtask

  task automatic test_known_vector();
    logic [W-1:0] exp_c [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    logic [W-1:0] res;
    logic err;
    int lat;
    load_cfg({5'd0, 5'd0, 5'd0});
    for (int i = 0; i < 5; i++) begin
      send(5'd0, res, err, lat);
      checks++;
      if (res !== exp_c[i] || err !== 1'b0) begin
        failures++;
        $display("FAIL known_vector[%0d]: got char=%0d err=%0d required char=%0d err=0",
                 i, res, err, exp_c[i]);
      end
      if (i == 0) begin
        checks++;
        if (lat != 8) begin
          failures++;
          $display("FAIL latency: got %0d cycles required 8", lat);
        end
      end
    end
    checks++;
    if (rotor_pos !== {5'd0, 5'd0, 5'd5}) begin
      failures++;
      $display("FAIL known_vector_pos: got %h required %h", rotor_pos, {5'd0, 5'd0, 5'd5});
    end
  endtask

  task automatic test_double_step();
    logic [N*W-1:0] exp_p [3] = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};
    logic [W-1:0] res;
    logic err;
    int lat;
    load_cfg({5'd0, 5'd3, 5'd20});
    for (int i = 0; i < 3; i++) begin
      send(5'd7, res, err, lat);
      checks++;
      if (rotor_pos !== exp_p[i]) begin
        failures++;
        $display("FAIL double_step[%0d]: got %h required %h", i, rotor_pos, exp_p[i]);
      end
    end
  endtask

  task automatic test_reciprocity();
    logic [W-1:0] plain [5] = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14};
    logic [W-1:0] exp_c [5] = '{5'd8, 5'd11, 5'd1, 5'd3, 5'd0};
    logic [W-1:0] ct [5];
    logic [W-1:0] res;
    logic err;
    int lat;
    load_cfg({5'd0, 5'd0, 5'd0});
    for (int i = 0; i < 5; i++) begin
      send(plain[i], ct[i], err, lat);
      checks++;
      if (ct[i] !== exp_c[i] || ct[i] === plain[i]) begin
        failures++;
        $display("FAIL encrypt_hello[%0d]: got %0d required %0d", i, ct[i], exp_c[i]);
      end
    end
    load_cfg({5'd0, 5'd0, 5'd0});
    for (int i = 0; i < 5; i++) begin
      send(ct[i], res, err, lat);
      checks++;
      if (res !== plain[i]) begin
        failures++;
        $display("FAIL decrypt_hello[%0d]: got %0d required %0d", i, res, plain[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int bad_char = 0;
    int bad_ready = 0;
    int bad_pos = 0;
    int bad_valid = 0;
    int extra = 0;
    load_cfg({5'd0, 5'd0, 5'd0});
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_char   = 5'd0;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      if (out_char !== 5'd1) bad_char++;
      if (in_ready !== 1'b0) bad_ready++;
      if (rotor_pos !== {5'd0, 5'd0, 5'd1}) bad_pos++;
      if (out_valid !== 1'b1) bad_valid++;
      tick();
    end
    checks++;
    if (bad_char != 0 || bad_valid != 0) begin
      failures++;
      $display("FAIL bp_hold: bad char cycles=%0d bad valid cycles=%0d required 0 0 (char=%0d)",
               bad_char, bad_valid, out_char);
    end
    checks++;
    if (bad_ready != 0 || bad_pos != 0) begin
      failures++;
      $display("FAIL bp_stall: bad in_ready cycles=%0d bad rotor_pos cycles=%0d required 0 0",
               bad_ready, bad_pos);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got out_valid=%0d in_ready=%0d required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL bp_single_handshake: got %0d extra valid cycles required 0", extra);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] res;
    logic err;
    int lat;
    int seen = 0;
    load_cfg({5'd0, 5'd0, 5'd7});
    send(5'd27, res, err, lat);
    checks++;
    if (res !== 5'd27 || err !== 1'b1 || lat != 0) begin
      failures++;
      $display("FAIL bad_letter: got char=%0d err=%0d extra_cycles=%0d required 27 1 0",
               res, err, lat);
    end
    checks++;
    if (rotor_pos !== {5'd0, 5'd0, 5'd7}) begin
      failures++;
      $display("FAIL bad_letter_no_step: got %h required %h", rotor_pos, {5'd0, 5'd0, 5'd7});
    end
    load_cfg({5'd0, 5'd0, 5'd25});
    send(5'd0, res, err, lat);
    checks++;
    if (rotor_pos !== {5'd0, 5'd0, 5'd0}) begin
      failures++;
      $display("FAIL z_wrap: got %h required %h", rotor_pos, {5'd0, 5'd0, 5'd0});
    end
    load_cfg({5'd2, 5'd1, 5'd30});
    checks++;
    if (rotor_pos !== {5'd2, 5'd1, 5'd0}) begin
      failures++;
      $display("FAIL cfg_out_of_range: got %h required %h", rotor_pos, {5'd2, 5'd1, 5'd0});
    end
    cfg_pos  = {5'd3, 5'd4, 5'd5};
    cfg_load = 1'b1;
    in_valid = 1'b1;
    in_char  = 5'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL cfg_blocks_ready: got in_ready=%0d required 0", in_ready);
    end
    tick();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (rotor_pos !== {5'd3, 5'd4, 5'd5}) begin
      failures++;
      $display("FAIL cfg_wins_load: got %h required %h", rotor_pos, {5'd3, 5'd4, 5'd5});
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1 || rotor_pos !== {5'd3, 5'd4, 5'd5}) begin
      failures++;
      $display("FAIL cfg_wins_no_accept: got valid_cycles=%0d in_ready=%0d pos=%h required 0 1 %h",
               seen, in_ready, rotor_pos, {5'd3, 5'd4, 5'd5});
    end
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    load_cfg({5'd0, 5'd0, 5'd0});
    in_valid = 1'b1;
    in_char  = 5'd0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_err} !== 3'b000 || out_char !== '0 || rotor_pos !== '0) begin
      failures++;
      $display("FAIL midop_reset: got rdy/vld/err=%b char=%0d pos=%h required 000 0 0",
               {in_ready, out_valid, out_err}, out_char, rotor_pos);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_ready: got %0d required 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midop_no_stale_valid: got %0d valid cycles required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_double_step();
    test_reciprocity();
    test_backpressure();
    test_boundaries();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
